// File: rtl/metronome_tempo_source.sv
// Metronome tempo source: debounced up/down buttons with auto-repeat
// set the BPM value; a phase accumulator emits one beat pulse per BPM period.

module metronome_tempo_source_btn #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_step
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } state_t;

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic [DW-1:0] dcnt;

  state_t        state;
  state_t        state_n;
  logic [RW-1:0] rcnt;
  logic [RW-1:0] rcnt_n;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      dcnt  <= '0;
    end else begin
      sync1 <= i_btn;
      sync2 <= sync1;
      // any agreement with the accepted level restarts the stability count
      if (sync2 == deb) begin
        dcnt <= '0;
      end else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb  <= sync2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_IDLE;
      rcnt  <= '0;
    end else begin
      state <= state_n;
      rcnt  <= rcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    rcnt_n  = rcnt;
    o_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (deb) begin
          o_step  = 1'b1;
          rcnt_n  = '0;
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!deb) begin
          state_n = ST_IDLE;
        end else if (rcnt == RW'(REPEAT_DELAY - 1)) begin
          o_step  = 1'b1;
          rcnt_n  = '0;
          state_n = ST_REPEAT;
        end else begin
          rcnt_n = rcnt + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!deb) begin
          state_n = ST_IDLE;
        end else if (rcnt == RW'(REPEAT_RATE - 1)) begin
          o_step = 1'b1;
          rcnt_n = '0;
        end else begin
          rcnt_n = rcnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

module metronome_tempo_source #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000,
  parameter int BPM_MIN         = 1,
  parameter int BPM_MAX         = 9999,
  parameter int BPM_DEFAULT     = 120
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_btn_up,
  input  logic        i_btn_down,
  input  logic        i_run,
  output logic        o_trigger,
  output logic [33:0] o_bpm_counter
);

  localparam logic [63:0] LIMIT64 = 64'(CLK_HZ) * 64'd60;
  localparam logic [33:0] LIMIT   = LIMIT64[33:0];
  localparam logic [33:0] B_MIN   = 34'(BPM_MIN);
  localparam logic [33:0] B_MAX   = 34'(BPM_MAX);
  localparam logic [33:0] B_DEF   = 34'(BPM_DEFAULT);

  logic        step_up;
  logic        step_dn;
  logic [33:0] bpm;
  logic [33:0] acc;
  logic [33:0] sum;

  metronome_tempo_source_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_btn_up (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_btn  (i_btn_up),
    .o_step (step_up)
  );

  metronome_tempo_source_btn #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_btn_dn (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_btn  (i_btn_down),
    .o_step (step_dn)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bpm <= B_DEF;
    end else if (step_up && !step_dn) begin
      bpm <= (bpm >= B_MAX) ? B_MAX : bpm + 34'd1;
    end else if (step_dn && !step_up) begin
      bpm <= (bpm <= B_MIN) ? B_MIN : bpm - 34'd1;
    end
  end

  assign sum = acc + bpm;

  // parked at LIMIT-1 so the first running edge always produces a beat
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc       <= LIMIT - 34'd1;
      o_trigger <= 1'b0;
    end else if (!i_run) begin
      acc       <= LIMIT - 34'd1;
      o_trigger <= 1'b0;
    end else if (sum >= LIMIT) begin
      acc       <= sum - LIMIT;
      o_trigger <= 1'b1;
    end else begin
      acc       <= sum;
      o_trigger <= 1'b0;
    end
  end

  assign o_bpm_counter = bpm;

endmodule
